// File: rtl/conv_ff_bank.sv
// conv_ff_bank: WIDTH-bit flip-flop bank with runtime D/T/SR/JK mode, SR-collision reporting; CONV_FF_BANK_ILLEGAL_CNT_EN adds a saturating illegal counter
module conv_ff_bank #(
  parameter int         WIDTH      = 8,
  parameter logic [1:0] RESET_MODE = 2'b00,
  parameter int         CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode_we,
  input  logic [1:0]       mode_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic [1:0]       mode_q,
  output logic             illegal,
`ifdef CONV_FF_BANK_ILLEGAL_CNT_EN
  output logic [CNT_W-1:0] illegal_cnt,
`endif
  output logic             err_sticky
);
  logic [WIDTH-1:0] q_q, q_d, sr_nx, jk_nx;
  logic [1:0]       mode_d;
  logic             illegal_q, illegal_d, err_q, err_d, hit;
  // next state: SR 1/1 falls into the hold term, JK 1/1 toggles
  always_comb begin
    sr_nx     = (a & ~b) | (q_q & ~(a ^ b));
    jk_nx     = (a & ~q_q) | (~b & q_q);
    hit       = en && mode_q == 2'b10 && |(a & b);
    q_d       = !en ? q_q :
                mode_q == 2'b00 ? a :
                mode_q == 2'b01 ? q_q ^ a :
                mode_q == 2'b10 ? sr_nx : jk_nx;
    mode_d    = mode_we ? mode_in : mode_q;
    illegal_d = hit;
    err_d     = hit | (err_q & ~err_clr);
  end
  // state registers, asynchronously cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q       <= '0;
      mode_q    <= RESET_MODE;
      illegal_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      q_q       <= q_d;
      mode_q    <= mode_d;
      illegal_q <= illegal_d;
      err_q     <= err_d;
    end
  end
`ifdef CONV_FF_BANK_ILLEGAL_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // count illegal cycles, sticking at all-ones
  always_comb cnt_d = (hit && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  // counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign illegal_cnt = cnt_q;
`endif
  assign q          = q_q;
  assign q_bar      = ~q_q;
  assign illegal    = illegal_q;
  assign err_sticky = err_q;
endmodule

// File: tb/tb_conv_ff_bank.sv
// tb_conv_ff_bank: directed and randomized checks of conv_ff_bank against a behavioural model
module tb_conv_ff_bank;
  localparam int W = 8;
  localparam int CW = 2;
  logic clk = 0, rst = 1, en = 0, mode_we = 0, err_clr = 0;
  logic [W-1:0] a = 0, b = 0, q, q_bar;
  logic [1:0] mode_in = 0, mode_q;
  logic illegal, err_sticky;
  logic [CW-1:0] illegal_cnt;
  int errors = 0, checks = 0;
  logic [W-1:0] m_q;
  logic [1:0] m_mode;
  logic m_ill, m_err;
  int m_cnt;

  conv_ff_bank #(.WIDTH(W), .RESET_MODE(2'b00), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .mode_we(mode_we),
    .mode_in(mode_in), .err_clr(err_clr), .q(q), .q_bar(q_bar),
    .mode_q(mode_q), .illegal(illegal),
`ifdef CONV_FF_BANK_ILLEGAL_CNT_EN
    .illegal_cnt(illegal_cnt),
`endif
    .err_sticky(err_sticky)
  );
`ifndef CONV_FF_BANK_ILLEGAL_CNT_EN
  assign illegal_cnt = '0;
`endif

  always #5 clk = ~clk;

  task automatic drive(input logic e, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic we, input logic [1:0] mi, input logic clr);
    @(negedge clk);
    en = e; a = av; b = bv; mode_we = we; mode_in = mi; err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_q = 0; m_mode = 0; m_ill = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    logic [W-1:0] nq;
    logic any;
    nq = m_q;
    any = 0;
    if (en) begin
      for (int i = 0; i < W; i++) begin
        case (m_mode)
          2'd0: nq[i] = a[i];
          2'd1: nq[i] = m_q[i] ^ a[i];
          2'd2: begin
            if (a[i] && !b[i]) nq[i] = 1;
            else if (!a[i] && b[i]) nq[i] = 0;
            if (a[i] && b[i]) any = 1;
          end
          default: begin
            if (a[i] && b[i]) nq[i] = !m_q[i];
            else if (a[i]) nq[i] = 1;
            else if (b[i]) nq[i] = 0;
          end
        endcase
      end
    end
    m_q = nq;
    m_ill = any;
    if (any) m_err = 1;
    else if (err_clr) m_err = 0;
    if (any && m_cnt < (1 << CW) - 1) m_cnt++;
    if (mode_we) m_mode = mode_in;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q got %h want 00", q); end
    checks++; if (q_bar !== 8'hFF) begin errors++; $display("FAIL reset_qbar got %h want ff", q_bar); end
    checks++; if (mode_q !== 2'b00) begin errors++; $display("FAIL reset_mode got %b want 00", mode_q); end
    checks++; if (illegal !== 1'b0 || err_sticky !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b want 00", illegal, err_sticky); end
    checks++; if (illegal_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d want 0", illegal_cnt); end
    @(negedge clk); rst = 0;
  endtask

  task automatic test_d_and_async_reset();
    drive(1, 8'hA5, 0, 0, 0, 0);
    checks++; if (q !== 8'hA5) begin errors++; $display("FAIL d_q got %h want a5", q); end
    checks++; if (q_bar !== 8'h5A) begin errors++; $display("FAIL d_qbar got %h want 5a", q_bar); end
    @(negedge clk);
    mode_we = 1; mode_in = 2'b11;
    #2 rst = 1;
    #1;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL async_rst_q got %h want 00", q); end
    @(posedge clk); #1;
    checks++; if (mode_q !== 2'b00) begin errors++; $display("FAIL rst_pending_mode got %b want 00", mode_q); end
    @(negedge clk); mode_we = 0; rst = 0;
  endtask

  task automatic test_mode_switch();
    drive(1, 8'hFF, 0, 1, 2'b01, 0);
    checks++; if (q !== 8'hFF) begin errors++; $display("FAIL switch_old_mode_q got %h want ff", q); end
    checks++; if (mode_q !== 2'b01) begin errors++; $display("FAIL switch_mode got %b want 01", mode_q); end
    drive(1, 8'h0F, 0, 0, 0, 0);
    checks++; if (q !== 8'hF0) begin errors++; $display("FAIL t_toggle got %h want f0", q); end
  endtask

  task automatic test_sr();
    drive(0, 0, 0, 1, 2'b00, 0);
    checks++; if (q !== 8'hF0) begin errors++; $display("FAIL mode_change_holds got %h want f0", q); end
    drive(1, 8'h00, 0, 1, 2'b10, 0);
    drive(1, 8'h03, 8'h01, 0, 0, 0);
    checks++; if (q !== 8'h02) begin errors++; $display("FAIL sr_q got %h want 02", q); end
    checks++; if (illegal !== 1'b1 || err_sticky !== 1'b1) begin errors++; $display("FAIL sr_flags got %b%b want 11", illegal, err_sticky); end
`ifdef CONV_FF_BANK_ILLEGAL_CNT_EN
    checks++; if (illegal_cnt !== 2'd1) begin errors++; $display("FAIL sr_cnt got %0d want 1", illegal_cnt); end
`endif
    drive(1, 0, 0, 0, 0, 0);
    checks++; if (q !== 8'h02 || illegal !== 1'b0) begin errors++; $display("FAIL sr_hold got q=%h ill=%b want 02 0", q, illegal); end
  endtask

  task automatic test_jk();
    drive(0, 0, 0, 1, 2'b00, 0);
    drive(1, 8'h0F, 0, 1, 2'b11, 0);
    drive(1, 8'hFF, 8'hFF, 0, 0, 0);
    checks++; if (q !== 8'hF0 || illegal !== 1'b0) begin errors++; $display("FAIL jk_toggle got q=%h ill=%b want f0 0", q, illegal); end
    drive(0, 8'hFF, 8'hFF, 0, 0, 0);
    checks++; if (q !== 8'hF0) begin errors++; $display("FAIL en_low_hold got %h want f0", q); end
  endtask

  task automatic test_err_clr();
    drive(0, 0, 0, 1, 2'b10, 0);
    drive(1, 8'h10, 8'h10, 0, 0, 1);
    checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL set_beats_clr got %b want 1", err_sticky); end
    drive(0, 0, 0, 0, 0, 1);
    checks++; if (err_sticky !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL clr got err=%b ill=%b want 0 0", err_sticky, illegal); end
  endtask

`ifdef CONV_FF_BANK_ILLEGAL_CNT_EN
  task automatic test_cnt_saturate();
    logic [CW-1:0] exp_cnt[4];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3};
    @(negedge clk); rst = 1; @(negedge clk); rst = 0;
    drive(0, 0, 0, 1, 2'b10, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 8'h81, 8'hFF, 0, 0, 0);
      checks++; if (illegal_cnt !== exp_cnt[i]) begin errors++; $display("FAIL cnt_%0d got %0d want %0d", i, illegal_cnt, exp_cnt[i]); end
    end
  endtask
`endif

  task automatic test_random();
    @(negedge clk); rst = 1; @(negedge clk); rst = 0;
    model_reset();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      en = ($urandom_range(0, 3) != 0);
      a = W'($urandom);
      b = ($urandom_range(0, 1) != 0) ? W'($urandom) : W'($urandom) & ~a;
      mode_we = ($urandom_range(0, 4) == 0);
      mode_in = 2'($urandom);
      err_clr = ($urandom_range(0, 5) == 0);
      @(posedge clk);
      model_step();
      #1;
      checks++;
      if (q !== m_q || q_bar !== ~m_q || mode_q !== m_mode || illegal !== m_ill || err_sticky !== m_err) begin
        errors++;
        $display("FAIL rand_%0d got q=%h qb=%h m=%b ill=%b err=%b want q=%h qb=%h m=%b ill=%b err=%b",
                 n, q, q_bar, mode_q, illegal, err_sticky, m_q, ~m_q, m_mode, m_ill, m_err);
      end
`ifdef CONV_FF_BANK_ILLEGAL_CNT_EN
      checks++;
      if (int'(illegal_cnt) != m_cnt) begin errors++; $display("FAIL rand_cnt_%0d got %0d want %0d", n, illegal_cnt, m_cnt); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_d_and_async_reset();
    test_mode_switch();
    test_sr();
    test_jk();
    test_err_clr();
`ifdef CONV_FF_BANK_ILLEGAL_CNT_EN
    test_cnt_saturate();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/conv_ff_bank.md
# conv_ff_bank

Parametrised multi-mode flip-flop bank: WIDTH independent storage bits sharing one clock, reset and runtime-selectable excitation mode (D, T, SR, JK). It is the general storage primitive for the team's flip-flop conversion designs, replacing single-bit fixed-mode converters. It also replaces the undefined SR 1/1 result with a defined hold, plus illegal-input reporting.

## Interface
Parameters:
- WIDTH, 8, number of storage bits (>=1)
- RESET_MODE, 2'b00, value loaded into mode_q on reset
- CNT_W, 8, width of illegal-event counter (>=1)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  update enable for q bank
- a  in  WIDTH  per-bit input A (D / T / S / J)
- b  in  WIDTH  per-bit input B (unused / unused / R / K)
- mode_we  in  1  write strobe for mode register
- mode_in  in  2  new mode: 00 D, 01 T, 10 SR, 11 JK
- err_clr  in  1  clears err_sticky
- q  out  WIDTH  stored state
- q_bar  out  WIDTH  combinational ~q
- mode_q  out  2  currently active mode
- illegal  out  1  registered: last enabled SR cycle had any bit with a&b
- err_sticky  out  1  latched illegal indication
- illegal_cnt  out  CNT_W  saturating illegal-cycle count (only with macro)

## Operation
- Reset (async assert): q=0, mode_q=RESET_MODE, illegal=0, err_sticky=0, illegal_cnt=0; q_bar=all ones.
- en=0: q holds; illegal<=0; no error or counter update.
- en=1, per bit i, using mode_q value before the edge:
  - D: q[i]<=a[i].
  - T: q[i]<=q[i]^a[i].
  - SR: {a,b}=00 hold, 01 clear, 10 set, 11 hold (never X) and bit flagged illegal.
  - JK: 00 hold, 01 clear, 10 set, 11 toggle.
- Illegal cycle: en=1, mode_q=SR and |(a&b)=1. Then illegal<=1, err_sticky<=1, illegal_cnt increments once per cycle regardless of how many bits collide.
- illegal_cnt saturates at 2^CNT_W-1; no wrap.
- err_clr=1 clears err_sticky; if an illegal cycle occurs in the same cycle, set wins (err_sticky=1).
- mode_we=1: mode_q<=mode_in. Bits in that same cycle evaluate with the old mode; new mode governs from the next edge. mode_we is independent of en.
- Mode change never alters q by itself.

## Timing
- q, mode_q, illegal, err_sticky, illegal_cnt: 1-cycle latency from inputs sampled at rising edge.
- q_bar: zero-latency combinational from q.
- rst deassertion: first update at the first rising edge with rst low.
- rst asserted mid-operation: all state clears immediately, including a pending mode_we.

## Configuration
- CONV_FF_BANK_ILLEGAL_CNT_EN defined: illegal_cnt port and CNT_W-bit saturating counter present, behaviour as above.
- Undefined: illegal_cnt port and counter absent; CNT_W ignored; illegal and err_sticky unchanged.

## Test plan
- Reset then D mode, WIDTH=8, en=1, a=8'hA5 -> q=8'hA5, q_bar=8'h5A one edge later; rst pulse mid-run -> q=0 immediately.
- mode_we with mode_in=01 while a=8'hFF, en=1 -> that edge loads q=8'hFF (D); next edge with a=8'h0F -> q=8'hF0 (T).
- SR mode, q=8'h00, a=8'h03, b=8'h01 -> q=8'h02, illegal=1, err_sticky=1, illegal_cnt=1; next cycle a=b=0 -> q=8'h02, illegal=0.
- JK mode, q=8'h0F, a=b=8'hFF -> q=8'hF0, illegal=0; en=0 with same inputs -> q holds 8'hF0.
- err_clr asserted in same cycle as SR illegal input -> err_sticky stays 1; err_clr alone next cycle -> err_sticky=0.
- With macro, CNT_W=2, four consecutive illegal SR cycles -> illegal_cnt 1,2,3,3 (saturated).
